// File: rtl/display_pkg.sv
// Shared types and helpers for the OUT-register display path:
// conversion FSM states, BCD width, digit adjust and segment encoding.
package display_pkg;

   localparam int unsigned BCD_DIGITS = 3;
   localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_t;

   // Double-dabble pre-shift correction: every nibble >= 5 gets +3.
   function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      r = s;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = r[4*i +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7_encode(input logic [3:0] nibble, input logic blank);
      logic [6:0] g;
      case (nibble)
         4'd0:    g = 7'b0111111;
         4'd1:    g = 7'b0000110;
         4'd2:    g = 7'b1011011;
         4'd3:    g = 7'b1001111;
         4'd4:    g = 7'b1100110;
         4'd5:    g = 7'b1101101;
         4'd6:    g = 7'b1111101;
         4'd7:    g = 7'b0000111;
         4'd8:    g = 7'b1111111;
         4'd9:    g = 7'b1101111;
         default: g = 7'b0000000;
      endcase
      return blank ? 7'b0000000 : g;
   endfunction

endpackage

// File: rtl/output_display_driver_bin_to_bcd_seq.sv
// Sequential 8-bit to 3-digit BCD converter: one double-dabble step per clock,
// result committed to o_bcd in the COMMIT state.
module bin_to_bcd_seq
   import display_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [7:0]       i_value,
   output logic             o_busy,
   output logic             o_commit,
   output logic [BCD_W-1:0] o_bcd
);

   conv_state_t      r_state;
   conv_state_t      w_state_nxt;
   logic [7:0]       r_bin;
   logic [BCD_W-1:0] r_scratch;
   logic [BCD_W-1:0] r_bcd;
   logic [2:0]       r_cnt;
   logic             w_load;
   logic             w_step;
   logic [BCD_W-1:0] w_adj;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; COMMIT may chain straight into a new conversion.
   always_comb begin
      w_state_nxt = IDLE;
      case (r_state)
         IDLE:    w_state_nxt = i_start ? SHIFT : IDLE;
         SHIFT:   w_state_nxt = (r_cnt == 3'd7) ? COMMIT : SHIFT;
         COMMIT:  w_state_nxt = i_start ? SHIFT : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output and datapath control decode.
   always_comb begin
      o_busy   = (r_state != IDLE);
      o_commit = (r_state == COMMIT);
      w_step   = (r_state == SHIFT);
      w_load   = i_start && ((r_state == IDLE) || (r_state == COMMIT));
      w_adj    = bcd_add3(r_scratch);
   end

   // Shift datapath and committed result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bin     <= 8'd0;
         r_scratch <= {BCD_W{1'b0}};
         r_cnt     <= 3'd0;
         r_bcd     <= {BCD_W{1'b0}};
      end else begin
         if (w_load) begin
            r_bin     <= i_value;
            r_scratch <= {BCD_W{1'b0}};
            r_cnt     <= 3'd0;
         end else if (w_step) begin
            r_scratch <= {w_adj[BCD_W-2:0], r_bin[7]};
            r_bin     <= {r_bin[6:0], 1'b0};
            r_cnt     <= r_cnt + 3'd1;
         end else begin
            r_bin     <= r_bin;
            r_scratch <= r_scratch;
            r_cnt     <= r_cnt;
         end
         if (o_commit) begin
            r_bcd <= r_scratch;
         end else begin
            r_bcd <= r_bcd;
         end
      end
   end

   assign o_bcd = r_bcd;

endmodule

// File: rtl/output_display_driver.sv
// OUT-register display driver: pending-load buffer in front of the BCD
// converter, digit scan, leading-zero blanking and segment polarity.
module output_display_driver
   import display_pkg::*;
#(
   parameter int DIGIT_PERIOD   = 4096,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       out_val,
   input  logic             out_load,
   output logic [6:0]       seg,
   output logic [2:0]       digit_en,
   output logic [BCD_W-1:0] bcd,
   output logic             busy
);

   localparam int CNT_W = $clog2(DIGIT_PERIOD);

   logic             w_busy;
   logic             w_commit;
   logic             w_start;
   logic [7:0]       w_value;
   logic [BCD_W-1:0] w_bcd;
   logic             r_pend_vld;
   logic [7:0]       r_pend_val;
   logic [CNT_W-1:0] r_scan_cnt;
   logic [1:0]       r_scan_idx;
   logic [3:0]       w_nib;
   logic             w_blank;
   logic [6:0]       w_seg_hi;

   // A load at the commit edge beats anything queued in the pending buffer.
   always_comb begin
      if (out_load) begin
         w_value = out_val;
      end else begin
         w_value = r_pend_val;
      end
      if (w_commit) begin
         w_start = out_load || r_pend_vld;
      end else begin
         w_start = out_load && !w_busy;
      end
   end

   bin_to_bcd_seq u_conv (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_start),
      .i_value  (w_value),
      .o_busy   (w_busy),
      .o_commit (w_commit),
      .o_bcd    (w_bcd)
   );

   // One-deep pending buffer, latest load wins, drained at every commit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_vld <= 1'b0;
         r_pend_val <= 8'd0;
      end else if (w_commit) begin
         r_pend_vld <= 1'b0;
         r_pend_val <= r_pend_val;
      end else if (out_load && w_busy) begin
         r_pend_vld <= 1'b1;
         r_pend_val <= out_val;
      end else begin
         r_pend_vld <= r_pend_vld;
         r_pend_val <= r_pend_val;
      end
   end

   // Digit scan counter and index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scan_cnt <= {CNT_W{1'b0}};
         r_scan_idx <= 2'd0;
      end else if (r_scan_cnt == CNT_W'(DIGIT_PERIOD - 1)) begin
         r_scan_cnt <= {CNT_W{1'b0}};
         r_scan_idx <= (r_scan_idx >= 2'd2) ? 2'd0 : r_scan_idx + 2'd1;
      end else begin
         r_scan_cnt <= r_scan_cnt + CNT_W'(1);
         r_scan_idx <= r_scan_idx;
      end
   end

   // Digit select with leading-zero blanking; decodes straight from committed bcd.
   always_comb begin
      case (r_scan_idx)
         2'd0: begin
            w_nib    = w_bcd[3:0];
            w_blank  = 1'b0;
            digit_en = 3'b110;
         end
         2'd1: begin
            w_nib    = w_bcd[7:4];
            w_blank  = (w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0);
            digit_en = 3'b101;
         end
         2'd2: begin
            w_nib    = w_bcd[11:8];
            w_blank  = (w_bcd[11:8] == 4'd0);
            digit_en = 3'b011;
         end
         default: begin
            w_nib    = w_bcd[3:0];
            w_blank  = 1'b0;
            digit_en = 3'b110;
         end
      endcase
      w_seg_hi = seg7_encode(w_nib, w_blank);
      if (SEG_ACTIVE_LOW) begin
         seg = ~w_seg_hi;
      end else begin
         seg = w_seg_hi;
      end
   end

   assign bcd  = w_bcd;
   assign busy = w_busy;

endmodule

// File: tb/tb_output_display_driver.sv
// Self-checking bench for output_display_driver: directed scenarios plus
// randomized loads/resets against a cycle-counting behavioural model.
module tb_output_display_driver;

   localparam int DP = 4;
   localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  out_val;
   logic        out_load;
   logic [6:0]  seg;
   logic [2:0]  digit_en;
   logic [11:0] bcd;
   logic        busy;

   int n_pass = 0;
   int n_chk  = 0;

   // Model: committed value, in-flight conversion, pending slot, scan time.
   int m_val, m_conv, m_left, m_pend, m_t;
   bit m_busy, m_pend_vld;

   always #5 clk = ~clk;

   output_display_driver #(.DIGIT_PERIOD(DP), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk      (clk),
      .reset    (reset),
      .out_val  (out_val),
      .out_load (out_load),
      .seg      (seg),
      .digit_en (digit_en),
      .bcd      (bcd),
      .busy     (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [2:0] exp_en(input int t);
      case ((t / DP) % 3)
         0:       return 3'b110;
         1:       return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input int t);
      int h, te, o, d;
      bit blank;
      h = v / 100; te = (v / 10) % 10; o = v % 10;
      case ((t / DP) % 3)
         0:       begin d = o;  blank = 1'b0; end
         1:       begin d = te; blank = (h == 0) && (te == 0); end
         default: begin d = h;  blank = (h == 0); end
      endcase
      return blank ? 7'h7F : ~SEG_TAB[d];
   endfunction

   task automatic model_reset();
      m_val = 0; m_conv = 0; m_left = 0; m_pend = 0; m_t = 0;
      m_busy = 1'b0; m_pend_vld = 1'b0;
   endtask

   task automatic model_step(input bit ld, input int v);
      m_t++;
      if (!m_busy) begin
         if (ld) begin m_busy = 1'b1; m_left = 9; m_conv = v; end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_val = m_conv;
            if (ld) begin
               m_conv = v; m_left = 9; m_pend_vld = 1'b0;
            end else if (m_pend_vld) begin
               m_conv = m_pend; m_left = 9; m_pend_vld = 1'b0;
            end else begin
               m_busy = 1'b0;
            end
         end else if (ld) begin
            m_pend_vld = 1'b1; m_pend = v;
         end
      end
   endtask

   task automatic check_all();
      check_val("bcd", bcd, to_bcd(m_val));
      check_val("busy", busy, m_busy);
      check_val("digit_en", digit_en, exp_en(m_t));
      check_val("seg", seg, exp_seg(m_val, m_t));
   endtask

   // Called at a negedge; drives inputs for one clock and checks at the next negedge.
   task automatic tick(input bit ld, input int v);
      out_load = ld;
      out_val  = 8'(v);
      @(posedge clk);
      if (reset) model_step(ld, v);
      @(negedge clk);
      out_load = 1'b0;
      check_all();
   endtask

   task automatic async_reset(input int hold);
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      for (int i = 0; i < hold; i++) tick(1'b0, 0);
      reset = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0);
   endtask

   task automatic wait_idx(input int k);
      for (int i = 0; i < 3 * DP && ((m_t / DP) % 3) != k; i++) tick(1'b0, 0);
   endtask

   initial begin
      reset = 1'b0; out_load = 1'b0; out_val = 8'd0;
      model_reset();
      // 1: reset state
      repeat (3) @(negedge clk);
      check_val("rst_bcd", bcd, 12'h000);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_en", digit_en, 3'b110);
      check_val("rst_seg", seg, 7'b1000000);
      reset = 1'b1;
      idle(2);

      // 2: max value, 9-cycle latency
      tick(1'b1, 255);
      idle(8);
      check_val("t2_busy_e8", busy, 1'b1);
      tick(1'b0, 0);
      check_val("t2_bcd", bcd, 12'h255);
      check_val("t2_busy_e9", busy, 1'b0);
      for (int k = 0; k < 3; k++) begin
         wait_idx(k);
         check_val("t2_scan_seg", seg, k == 2 ? 7'b0100100 : 7'b0010010);
      end

      // 3: leading-zero blanking
      tick(1'b1, 7);
      idle(9);
      check_val("t3_bcd", bcd, 12'h007);
      wait_idx(0); check_val("t3_ones", seg, 7'b1111000);
      wait_idx(1); check_val("t3_tens", seg, 7'b1111111);
      wait_idx(2); check_val("t3_hund", seg, 7'b1111111);

      // 4: pending buffer, latest wins, back-to-back commit
      tick(1'b1, 100);
      idle(1);
      tick(1'b1, 42);
      tick(1'b1, 9);
      idle(6);
      check_val("t4_first", bcd, 12'h100);
      check_val("t4_chain_busy", busy, 1'b1);
      idle(9);
      check_val("t4_second", bcd, 12'h009);
      check_val("t4_done", busy, 1'b0);

      // 5: reset mid-conversion aborts
      tick(1'b1, 200);
      idle(3);
      async_reset(2);
      check_val("t5_bcd", bcd, 12'h000);
      idle(20);
      check_val("t5_nocommit", bcd, 12'h000);

      // 6: scan of 123 over several wraps
      tick(1'b1, 123);
      idle(9 + 6 * DP);
      check_val("t6_bcd", bcd, 12'h123);

      // Randomized loads with occasional asynchronous resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) async_reset(1);
         else tick($urandom_range(0, 5) == 0, int'($urandom_range(0, 255)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
